// File: rtl/if_id_inst_queue_if.sv
// IF -> queue -> ID handshake bundle for the dual-issue instruction queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface if_id_inst_queue_if #(
  parameter int DATA_W = 64,
  parameter int PTR_W  = 3
);
  logic              excep_flush_i;
  logic              in_valid1_i;
  logic              in_valid2_i;
  logic [DATA_W-1:0] in_data1_i;
  logic [DATA_W-1:0] in_data2_i;
  logic              allowin_o;
  logic              out_valid1_o;
  logic              out_valid2_o;
  logic [DATA_W-1:0] out_data1_o;
  logic [DATA_W-1:0] out_data2_o;
  logic [1:0]        pop_num_i;
  logic [PTR_W:0]    count_o;

  modport slave (
    input  excep_flush_i, in_valid1_i, in_valid2_i, in_data1_i, in_data2_i, pop_num_i,
    output allowin_o, out_valid1_o, out_valid2_o, out_data1_o, out_data2_o, count_o
  );

  modport master (
    output excep_flush_i, in_valid1_i, in_valid2_i, in_data1_i, in_data2_i, pop_num_i,
    input  allowin_o, out_valid1_o, out_valid2_o, out_data1_o, out_data2_o, count_o
  );
endinterface

// File: rtl/if_id_inst_queue.sv
// Dual-issue IF->ID instruction queue: circular RAM, 0/1/2 pushes and pops per cycle.
// Optional zero-latency bypass of fetch inputs when IF_ID_IQ_BYPASS_EN is defined.
module if_id_inst_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int PTR_W  = 3
) (
  input logic               clk,
  input logic               rst_n,
  if_id_inst_queue_if.slave iq
);

  localparam int CW = PTR_W + 1;
  localparam int AW = CW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     head, tail, count;
  logic [PTR_W-1:0]  h0, h1, t0, t1;
  logic              allowin;
  logic [1:0]        push_n, pop_req, pop_store, wr_n;
  logic [DATA_W-1:0] wr_d0;

  assign count   = tail - head;
  assign allowin = (count <= CW'(DEPTH - 2));
  assign h0      = head[PTR_W-1:0];
  assign h1      = h0 + PTR_W'(1);
  assign t0      = tail[PTR_W-1:0];
  assign t1      = t0 + PTR_W'(1);

  // slot 2 is only honoured together with slot 1
  always_comb begin
    push_n = 2'd0;
    if (allowin && iq.in_valid1_i) push_n = iq.in_valid2_i ? 2'd2 : 2'd1;
    pop_req = (iq.pop_num_i == 2'd3) ? 2'd2 : iq.pop_num_i;
  end

`ifdef IF_ID_IQ_BYPASS_EN
  logic [AW-1:0] avail;
  logic [1:0]    pop_n, pop_in;

  // the visible window is stored entries followed by this cycle's accepted inputs
  assign avail = AW'(count) + AW'(push_n);

  always_comb begin
    pop_n     = (AW'(pop_req) > avail) ? avail[1:0] : pop_req;
    pop_store = (CW'(pop_n) > count) ? count[1:0] : pop_n;
    pop_in    = pop_n - pop_store;
    wr_n      = push_n - pop_in;
    wr_d0     = (pop_in == 2'd0) ? iq.in_data1_i : iq.in_data2_i;
  end

  assign iq.out_valid1_o = !iq.excep_flush_i && (avail >= AW'(1));
  assign iq.out_valid2_o = !iq.excep_flush_i && (avail >= AW'(2));
  assign iq.out_data1_o  = (count != '0) ? mem[h0] : iq.in_data1_i;
  assign iq.out_data2_o  = (count >= CW'(2)) ? mem[h1] :
                           (count == CW'(1)) ? iq.in_data1_i : iq.in_data2_i;
`else
  always_comb begin
    pop_store = (CW'(pop_req) > count) ? count[1:0] : pop_req;
    wr_n      = push_n;
    wr_d0     = iq.in_data1_i;
  end

  assign iq.out_valid1_o = (count >= CW'(1));
  assign iq.out_valid2_o = (count >= CW'(2));
  assign iq.out_data1_o  = mem[h0];
  assign iq.out_data2_o  = mem[h1];
`endif

  assign iq.allowin_o = allowin;
  assign iq.count_o   = count;

  // pointer update: flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (iq.excep_flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + CW'(pop_store);
      tail <= tail + CW'(wr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!iq.excep_flush_i) begin
      if (wr_n != 2'd0) mem[t0] <= wr_d0;
      if (wr_n == 2'd2) mem[t1] <= iq.in_data2_i;
    end
  end

endmodule
